muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Iterative sequencer for the RV32M multiply/divide instructions. It sits beside the execute-stage ALU and is launched by execute when an M-extension op (funct7 = 0000001) is decoded. It holds the execute stage stalled through `busy_o` until the result completes, then returns the 32-bit result over a valid/ready handshake. A single radix-2 shift-add / restoring-divide engine is shared by all eight ops.

Parameters:
XLEN, 32, operand/result width; only 32 is supported; the iteration counter width is derived as $clog2(XLEN).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush_i  in  1  abort current op (branch/trap flush)
start_i  in  1  launch request from execute
ready_o  out  1  can accept start; equals (state == IDLE)
op_i  in  3  funct3 encoding, type muldiv_op_e: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
rs1_i  in  XLEN  operand A
rs2_i  in  XLEN  operand B
busy_o  out  1  op in flight; execute uses it as its stall input
valid_o  out  1  result_o valid
next_ready_i  in  1  consumer accepts the result
result_o  out  XLEN  result

Behaviour:
- FSM states: IDLE, MUL, DIV, DONE.
- Reset (async): state = IDLE; valid_o = 0, busy_o = 0, result_o = 0, counter = 0; ready_o = 1.
- Accept: start_i && ready_o && !flush_i at a clock edge. On accept:
  - latch op, operand magnitudes and the result sign;
  - counter = 0; busy_o = 1.
- Signedness rules:
  - MULH and DIV/REM treat both operands as signed.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - MULHU, DIVU and REMU treat both as unsigned.
- Special cases, resolved at accept, go straight to DONE; valid_o rises on the next edge (1-cycle latency):
  - DIV/DIVU with rs2 = 0: quotient = 0xFFFFFFFF.
  - REM/REMU with rs2 = 0: result = rs1.
  - DIV with 0x80000000 / 0xFFFFFFFF: result = 0x80000000.
  - REM with 0x80000000 / 0xFFFFFFFF: result = 0.
- MUL state: one shift-add step per cycle into a 64-bit accumulator. After the 32nd step (counter == 31), go to DONE.
- DIV state: one restoring step per cycle (33-bit partial remainder). After 32 steps, go to DONE.
- Result negation and hi/lo selection are applied on the edge entering DONE, so result_o is registered.
- Normal latency: valid_o first high 33 edges after the accept edge.
- Quotient sign = sign(rs1) XOR sign(rs2). Remainder sign = sign(rs1).
- DONE:
  - valid_o = 1, busy_o = 1.
  - result_o and valid_o hold stable while next_ready_i = 0.
  - valid_o && next_ready_i → IDLE; valid_o and busy_o drop on that edge.
  - There is no back-to-back accept in the same cycle as the result handshake.
- Flush:
  - flush_i in any state → IDLE on the next edge; valid_o = 0, busy_o = 0, result_o unchanged.
  - flush_i has priority over start_i and over the DONE handshake.
- Reset mid-operation: immediate return to IDLE; the partial result is discarded.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: MUL-family ops exit to DONE once the remaining multiplier magnitude bits are all zero, after at least 1 step. Latency = 1 + bit index of the multiplier MSB + 1 edges; multiplier = 0 takes 2 edges. Division latency is unchanged.
- Undefined: fixed 32-step multiply; the early-out logic is absent.

Decomposition:
- core_package:
  - muldiv_op_e, 3-bit enum matching funct3;
  - muldiv_state_e;
  - constant OPCODE_FUNCT7_MULDIV = 7'b0000001.
- One sub-module, muldiv_step: combinational single iteration. Inputs are accumulator/remainder, operand and mode (mul/div); outputs are the next accumulator/remainder and the quotient bit. muldiv_ctrl owns the FSM, counter, sign fixup and handshake.

Test Plan:
1. MUL, rs1 = 7, rs2 = 0xFFFFFFFD → result_o = 0xFFFFFFEB; valid_o rises exactly 33 edges after accept; busy_o high throughout.
2. With rs1 = rs2 = 0xFFFFFFFF:
   - MULHU → 0xFFFFFFFE;
   - MULH → 0x00000000;
   - MULHSU → 0xFFFFFFFF.
3. DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
4. Special cases, each with valid_o one edge after accept:
   - DIVU 5/0 → 0xFFFFFFFF;
   - REM 5/0 → 5;
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000;
   - REM of the same → 0.
5. Flush and reset:
   - flush_i at cycle 10 of a DIV → valid_o never asserts, ready_o = 1 next edge;
   - start_i together with flush_i is not accepted;
   - async reset mid-MUL → IDLE with all outputs at reset values.
6. Backpressure: hold next_ready_i = 0 for 5 cycles in DONE → valid_o and result_o stable; release → IDLE next edge. With MULDIV_EARLY_OUT_EN, MUL 3*5 → 15 with valid_o 3 edges after accept.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared types and constants for the RV32M multiply/divide sequencer
package muldiv_ctrl_pkg;

   localparam logic [6:0] OPCODE_FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef logic [1:0] muldiv_state_e;

   localparam muldiv_state_e ST_IDLE = 2'd0;
   localparam muldiv_state_e ST_MUL  = 2'd1;
   localparam muldiv_state_e ST_DIV  = 2'd2;
   localparam muldiv_state_e ST_DONE = 2'd3;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add (mul) or restoring-divide (div) iteration
module muldiv_step
   import muldiv_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                mode_div,
   input  logic [2*XLEN-1:0]   acc,
   input  logic [2*XLEN-1:0]   operand,
   input  logic                in_bit,
   output logic [2*XLEN-1:0]   acc_next,
   output logic                q_bit
);

   logic [XLEN:0]   shifted;
   logic [XLEN+1:0] diff;

   // Divide: the partial remainder lives in acc[XLEN:0]; a borrow out of diff means restore.
   always_comb begin
      shifted  = {acc[XLEN-1:0], in_bit};
      diff     = {1'b0, shifted} - {2'b00, operand[XLEN-1:0]};
      q_bit    = 1'b0;
      acc_next = acc;
      if (mode_div) begin
         q_bit    = ~diff[XLEN+1];
         acc_next = {{(XLEN-1){1'b0}}, (q_bit ? diff[XLEN:0] : shifted)};
      end else begin
         acc_next = acc + (in_bit ? operand : '0);
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - RV32M iterative mul/div sequencer; MULDIV_EARLY_OUT_EN enables multiply early exit
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush_i,
   input  logic              start_i,
   output logic              ready_o,
   input  logic [2:0]        op_i,
   input  logic [XLEN-1:0]   rs1_i,
   input  logic [XLEN-1:0]   rs2_i,
   output logic              busy_o,
   output logic              valid_o,
   input  logic              next_ready_i,
   output logic [XLEN-1:0]   result_o
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_e     state;
   muldiv_op_e        op_q;
   logic [2*XLEN-1:0] acc, a_reg, acc_step, prod;
   logic [XLEN-1:0]   b_reg, b_next, mag1, mag2, mul_res, div_raw, div_res;
   logic [CW-1:0]     cnt;
   logic              neg_q, q_bit, mul_last;
   logic              rs1_signed, rs2_signed, neg1, neg2, is_div, is_rem, div0, ovf;

   assign ready_o = (state == ST_IDLE);
   assign busy_o  = (state != ST_IDLE);

   muldiv_step #(.XLEN(XLEN)) u_step (
      .mode_div (state == ST_DIV),
      .acc      (acc),
      .operand  (a_reg),
      .in_bit   ((state == ST_DIV) ? b_reg[XLEN-1] : b_reg[0]),
      .acc_next (acc_step),
      .q_bit    (q_bit)
   );

   always_comb begin
      rs1_signed = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                   (op_i == OP_DIV) || (op_i == OP_REM);
      rs2_signed = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
      neg1       = rs1_signed & rs1_i[XLEN-1];
      neg2       = rs2_signed & rs2_i[XLEN-1];
      mag1       = neg1 ? -rs1_i : rs1_i;
      mag2       = neg2 ? -rs2_i : rs2_i;
      is_div     = op_i[2];
      is_rem     = op_i[2] & op_i[1];
      div0       = is_div && (rs2_i == '0);
      ovf        = ((op_i == OP_DIV) || (op_i == OP_REM)) && (rs1_i == INT_MIN) && (rs2_i == ALL_ONES);
   end

   // Final-step results: sign fixup and hi/lo selection land in result_o on the edge entering DONE.
   always_comb begin
      b_next  = {b_reg[XLEN-2:0], q_bit};
      prod    = neg_q ? -acc_step : acc_step;
      mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      div_raw = op_q[1] ? acc_step[XLEN-1:0] : b_next;
      div_res = neg_q ? -div_raw : div_raw;
`ifdef MULDIV_EARLY_OUT_EN
      mul_last = (cnt == CW'(XLEN-1)) || (b_reg[XLEN-1:1] == '0);
`else
      mul_last = (cnt == CW'(XLEN-1));
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         op_q     <= OP_MUL;
         acc      <= '0;
         a_reg    <= '0;
         b_reg    <= '0;
         cnt      <= '0;
         neg_q    <= 1'b0;
         valid_o  <= 1'b0;
         result_o <= '0;
      end else if (flush_i) begin
         state   <= ST_IDLE;
         valid_o <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  op_q  <= muldiv_op_e'(op_i);
                  cnt   <= '0;
                  acc   <= '0;
                  a_reg <= {{XLEN{1'b0}}, mag2};
                  b_reg <= mag1;
                  neg_q <= is_rem ? neg1 : (neg1 ^ neg2);
                  if (div0) begin
                     result_o <= is_rem ? rs1_i : ALL_ONES;
                     state    <= ST_DONE;
                  end else if (ovf) begin
                     result_o <= is_rem ? '0 : INT_MIN;
                     state    <= ST_DONE;
                  end else begin
                     state <= is_div ? ST_DIV : ST_MUL;
                  end
               end
            end
            ST_MUL: begin
               acc   <= acc_step;
               a_reg <= a_reg << 1;
               b_reg <= b_reg >> 1;
               cnt   <= cnt + CW'(1);
               if (mul_last) begin
                  result_o <= mul_res;
                  state    <= ST_DONE;
               end
            end
            ST_DIV: begin
               acc   <= acc_step;
               b_reg <= b_next;
               cnt   <= cnt + CW'(1);
               if (cnt == CW'(XLEN-1)) begin
                  result_o <= div_res;
                  state    <= ST_DONE;
               end
            end
            default: begin
               if (valid_o && next_ready_i) begin
                  state   <= ST_IDLE;
                  valid_o <= 1'b0;
               end else begin
                  valid_o <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl
module tb_muldiv_ctrl;
   import muldiv_ctrl_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int LAT_MUL7 = 4;
   localparam int LAT_MUL3 = 3;
`else
   localparam int LAT_MUL7 = 33;
   localparam int LAT_MUL3 = 33;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush_i = 1'b0;
   logic        start_i = 1'b0;
   logic        next_ready_i = 1'b0;
   logic [2:0]  op_i = 3'd0;
   logic [31:0] rs1_i = '0;
   logic [31:0] rs2_i = '0;
   logic        ready_o, busy_o, valid_o;
   logic [31:0] result_o;

   muldiv_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .flush_i      (flush_i),
      .start_i      (start_i),
      .ready_o      (ready_o),
      .op_i         (op_i),
      .rs1_i        (rs1_i),
      .rs2_i        (rs2_i),
      .busy_o       (busy_o),
      .valid_o      (valid_o),
      .next_ready_i (next_ready_i),
      .result_o     (result_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          t0;
      string       name;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   logic vprev = 1'b0;
   always @(negedge clk) begin : monitor
      exp_t e;
      if (valid_o && !vprev) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid actual=%h required=no_result", result_o);
         end else begin
            e = sbq.pop_front();
            chk({e.name, "_result"}, result_o, e.res);
            chk({e.name, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
            chk({e.name, "_busy_in_done"}, {31'd0, busy_o}, 32'd1);
         end
      end
      vprev = valid_o;
   end

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat, input string nm, input int hold);
      exp_t        e;
      int          n;
      logic        busy_ok;
      logic [31:0] r;
      n = 0;
      while (!ready_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      op_i    = op;
      rs1_i   = a;
      rs2_i   = b;
      start_i = 1'b1;
      @(posedge clk);
      #1;
      e.res  = res;
      e.lat  = lat;
      e.t0   = cyc;
      e.name = nm;
      sbq.push_back(e);
      @(negedge clk);
      start_i = 1'b0;
      busy_ok = 1'b1;
      n = 0;
      while (!valid_o && n < 100) begin
         if (!busy_o) busy_ok = 1'b0;
         @(negedge clk);
         n++;
      end
      if (!valid_o) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=no_valid required=valid", nm);
         return;
      end
      chk({nm, "_busy_throughout"}, {31'd0, busy_ok}, 32'd1);
      r = result_o;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({nm, "_hold_valid"}, {31'd0, valid_o}, 32'd1);
         chk({nm, "_hold_result"}, result_o, r);
      end
      next_ready_i = 1'b1;
      @(negedge clk);
      next_ready_i = 1'b0;
      chk({nm, "_idle_after_hs"}, {30'd0, ready_o, valid_o}, 32'd2);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      logic seen;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {29'd0, ready_o, busy_o, valid_o}, 32'd4);
      chk("reset_result", result_o, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op(OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_MUL7, "mul_7_m3", 0);
      run_op(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu_ff", 0);
      run_op(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, "mulh_ff", 0);
      run_op(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mulhsu_ff", 0);
      run_op(OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div_m7_2", 0);
      run_op(OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem_m7_2", 0);
      run_op(OP_DIVU,   32'd100,      32'd7,        32'd14,       33, "divu_100_7", 0);
      run_op(OP_REMU,   32'd100,      32'd7,        32'd2,        33, "remu_100_7", 0);
      run_op(OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1,  "divu_by0", 0);
      run_op(OP_REM,    32'd5,        32'd0,        32'd5,        1,  "rem_by0", 0);
      run_op(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf", 0);
      run_op(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  "rem_ovf", 0);
      run_op(OP_MUL,    32'd3,        32'd5,        32'd15,       LAT_MUL3, "mul_3_5_bp", 5);

      // Flush ten cycles into a divide: no result may ever appear.
      op_i = OP_DIV; rs1_i = 32'd1000; rs2_i = 32'd3; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (9) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      chk("flush_idle", {29'd0, ready_o, busy_o, valid_o}, 32'd4);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (valid_o) seen = 1'b1;
      end
      chk("flush_no_valid", {31'd0, seen}, 32'd0);

      op_i = OP_MUL; rs1_i = 32'd9; rs2_i = 32'd9; start_i = 1'b1; flush_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0; flush_i = 1'b0;
      chk("start_with_flush", {30'd0, ready_o, busy_o}, 32'd2);

      op_i = OP_MUL; rs1_i = 32'h12345; rs2_i = 32'h777; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk("mul_started", {31'd0, busy_o}, 32'd1);
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("reset_mid_outputs", {29'd0, ready_o, busy_o, valid_o}, 32'd4);
      chk("reset_mid_result", result_o, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_reset_idle", {29'd0, ready_o, busy_o, valid_o}, 32'd4);
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
